// File: rtl/word_fifo32.sv
// Synchronous 32-bit word FIFO behind the byte packer. Read data is registered.
// Occupancy flags are registered from the next count. Overflow and underflow are sticky.
module word_fifo32 #(
    parameter int DEPTH        = 8,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                       clk_f,
    input  logic                       reset,
    input  logic [31:0]                data_in,
    input  logic                       valid_in,
    input  logic                       pop,
    output logic [31:0]                data_out,
    output logic                       valid_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;
    logic [CW-1:0] count_next;

    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = valid_in && (!full || pop_ok);

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok)
            count_next = count + 1'b1;
        else if (!push_ok && pop_ok)
            count_next = count - 1'b1;
    end

    // Storage is not cleared on reset; the pointers alone define valid contents.
    always_ff @(posedge clk_f) begin
        if (push_ok)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            valid_out    <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            valid_out    <= pop_ok;
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            if (valid_in && !push_ok)
                overflow <= 1'b1;
            if (pop && empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_word_fifo32.sv
// Self-checking bench for word_fifo32: directed scenarios plus random traffic.
// A queue-based reference model predicts every output after each clock edge.
module tb_word_fifo32;

    localparam int DEPTH = 8;

    logic        clk_f = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        pop;
    logic [31:0] data_out;
    logic        valid_out;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    word_fifo32 #(.DEPTH(DEPTH), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) dut (
        .clk_f(clk_f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .pop(pop), .data_out(data_out), .valid_out(valid_out), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk_f = ~clk_f;

    int checks = 0;
    int errors = 0;

    logic [31:0] q [$];
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ovf;
    logic        m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_all(input string where);
        int n;
        n = q.size();
        check({where, ".count"},        32'(count),        32'(n));
        check({where, ".full"},         32'(full),         32'(n == DEPTH));
        check({where, ".empty"},        32'(empty),        32'(n == 0));
        check({where, ".almost_full"},  32'(almost_full),  32'(n >= 6));
        check({where, ".almost_empty"}, 32'(almost_empty), 32'(n <= 2));
        check({where, ".overflow"},     32'(overflow),     32'(m_ovf));
        check({where, ".underflow"},    32'(underflow),    32'(m_unf));
        check({where, ".valid_out"},    32'(valid_out),    32'(m_valid));
        check({where, ".data_out"},     data_out,          m_data);
    endtask

    // One clock with the given request pattern; model advanced from the pre-edge occupancy.
    task automatic cycle(input string where, input logic v, input logic [31:0] d, input logic p);
        bit pop_ok;
        bit push_ok;
        valid_in = v;
        data_in  = d;
        pop      = p;
        @(posedge clk_f);
        #1;
        pop_ok  = p && (q.size() != 0);
        push_ok = v && ((q.size() < DEPTH) || pop_ok);
        if (p && q.size() == 0) m_unf = 1'b1;
        if (v && !push_ok)      m_ovf = 1'b1;
        if (pop_ok) begin
            m_data  = q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (push_ok) q.push_back(d);
        check_all(where);
        valid_in = 1'b0;
        pop      = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        pop      = 1'b0;
        data_in  = '0;
        @(posedge clk_f);
        #1;
        reset = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        pop      = 1'b0;
        data_in  = '0;
        model_reset();
        #2;
        check_all("por");
        do_reset();

        // Two pushes, two pops
        cycle("t1.push", 1'b1, 32'h1122_3344, 1'b0);
        cycle("t1.push", 1'b1, 32'hAABB_CCDD, 1'b0);
        cycle("t1.pop", 1'b0, 32'h0, 1'b1);
        check("t1.first_word", data_out, 32'h1122_3344);
        check("t1.first_valid", 32'(valid_out), 32'd1);
        cycle("t1.pop", 1'b0, 32'h0, 1'b1);
        check("t1.second_word", data_out, 32'hAABB_CCDD);
        check("t1.end_empty", 32'(empty), 32'd1);
        check("t1.end_count", 32'(count), 32'd0);

        // Fill, then overflow push
        for (int i = 0; i < DEPTH; i++) cycle("t2.fill", 1'b1, 32'(i), 1'b0);
        cycle("t2.ovf", 1'b1, 32'hDEAD_BEEF, 1'b0);
        check("t2.full", 32'(full), 32'd1);
        check("t2.count", 32'(count), 32'd8);
        check("t2.overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle("t2.drain", 1'b0, 32'h0, 1'b1);
            check("t2.drain_word", data_out, 32'(i));
        end
        cycle("t2.idle", 1'b0, 32'h0, 1'b1);
        check("t2.no_deadbeef", 32'(valid_out), 32'd0);

        // Simultaneous push and pop while full
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle("t3.fill", 1'b1, 32'(i), 1'b0);
        cycle("t3.both", 1'b1, 32'h55, 1'b1);
        check("t3.oldest", data_out, 32'h0);
        check("t3.count", 32'(count), 32'd8);
        check("t3.no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle("t3.drain", 1'b0, 32'h0, 1'b1);
        check("t3.last", data_out, 32'h55);

        // Pop on empty with same-cycle push
        cycle("t4.both", 1'b1, 32'h99, 1'b1);
        check("t4.underflow", 32'(underflow), 32'd1);
        check("t4.valid", 32'(valid_out), 32'd0);
        check("t4.count", 32'(count), 32'd1);
        cycle("t4.pop", 1'b0, 32'h0, 1'b1);
        check("t4.word", data_out, 32'h99);

        // Streaming at occupancy 3 across pointer wraps
        do_reset();
        for (int i = 0; i < 3; i++) cycle("t5.prime", 1'b1, 32'(100 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle("t5.stream", 1'b1, 32'(200 + i), 1'b1);
            check("t5.order", data_out, (i < 3) ? 32'(100 + i) : 32'(200 + i - 3));
            check("t5.ae_low", 32'(almost_empty), 32'd0);
        end
        cycle("t5.drop", 1'b0, 32'h0, 1'b1);
        check("t5.ae_high", 32'(almost_empty), 32'd1);

        // Asynchronous reset between edges with five words stored
        for (int i = 0; i < 3; i++) cycle("t6.fill", 1'b1, 32'(300 + i), 1'b0);
        check("t6.count5", 32'(count), 32'd5);
        cycle("t6.pop", 1'b0, 32'h0, 1'b1);
        cycle("t6.refill", 1'b1, 32'h400, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        @(posedge clk_f);
        #3;
        reset = 1'b0;
        cycle("t6.pop_after", 1'b0, 32'h0, 1'b1);
        check("t6.underflow", 32'(underflow), 32'd1);

        // Random traffic with drifting push/pop bias
        do_reset();
        for (int i = 0; i < 480; i++) begin
            int push_pct;
            int pop_pct;
            push_pct = ((i / 60) % 2 == 0) ? 75 : 30;
            pop_pct  = ((i / 60) % 2 == 0) ? 30 : 75;
            cycle("rand", ($urandom_range(99) < push_pct), $urandom(),
                  ($urandom_range(99) < pop_pct));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
